// File: rtl/dsram_axi_slave_if.sv
// AXI4-Lite style load/store channel bundle between the EXU dsram port and the data SRAM slave.
interface dsram_axi_slave_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [2:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [DATA_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/dsram_axi_slave.sv
// Word-addressed data SRAM behind an AXI4-Lite style slave with independent fixed-latency
// read and write channels; loads come back right-aligned, stores use the EXU size strobe.
module dsram_axi_slave #(
  parameter int unsigned          DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] ADDR_BASE  = 32'h8000_0000,
  parameter int unsigned          DEPTH_WORDS = 4096,
  parameter int unsigned          RD_LAT      = 1,
  parameter int unsigned          WR_LAT      = 1
) (
  input logic             clk,
  input logic             rst,
  dsram_axi_slave_if.slave bus
);

  localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
  localparam int unsigned NBYTES = DATA_WIDTH / 8;
  localparam int unsigned RC_W   = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int unsigned WC_W   = (WR_LAT > 1) ? $clog2(WR_LAT) : 1;
  localparam logic [DATA_WIDTH-1:0] SPAN = DATA_WIDTH'(NBYTES * DEPTH_WORDS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  function automatic logic in_range(input logic [DATA_WIDTH-1:0] a);
    logic [DATA_WIDTH-1:0] ofs;
    ofs = a - ADDR_BASE;
    return (a >= ADDR_BASE) && (ofs < SPAN);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [DATA_WIDTH-1:0] a);
    return IDX_W'((a - ADDR_BASE) >> 2);
  endfunction

  // ---------------- read channel ----------------
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;

  r_state_t              r_state, r_state_n;
  logic [RC_W-1:0]       r_cnt, r_cnt_n;
  logic [DATA_WIDTH-1:0] r_addr;
  logic                  ar_hs;
  logic                  r_load;

  assign ar_hs = bus.arvalid && bus.arready;

  // R_WAIT spans RD_LAT edges; the last one samples the array and raises rvalid
  always_comb begin
    r_state_n = r_state;
    r_cnt_n   = r_cnt;
    r_load    = 1'b0;
    case (r_state)
      R_IDLE: if (ar_hs) begin
        r_state_n = R_WAIT;
        r_cnt_n   = RC_W'(RD_LAT - 1);
      end
      R_WAIT: if (r_cnt == '0) begin
        r_state_n = R_RESP;
        r_load    = 1'b1;
      end else begin
        r_cnt_n = r_cnt - RC_W'(1);
      end
      R_RESP: if (bus.rready) r_state_n = R_IDLE;
      default: r_state_n = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= R_IDLE;
      r_cnt       <= '0;
      r_addr      <= '0;
      bus.arready <= 1'b1;
      bus.rvalid  <= 1'b0;
      bus.rdata   <= '0;
      bus.rresp   <= RESP_OKAY;
    end else begin
      r_state     <= r_state_n;
      r_cnt       <= r_cnt_n;
      bus.arready <= (r_state_n == R_IDLE);
      bus.rvalid  <= (r_state_n == R_RESP);
      if (ar_hs) r_addr <= bus.araddr;
      // Array read is ordered before a same-edge commit, so a colliding read sees old data
      if (r_load) begin
        if (in_range(r_addr)) begin
          bus.rdata <= mem[word_idx(r_addr)] >> {r_addr[1:0], 3'b000};
          bus.rresp <= RESP_OKAY;
        end else begin
          bus.rdata <= '0;
          bus.rresp <= RESP_SLVERR;
        end
      end
    end
  end

  // ---------------- write channel ----------------
  typedef enum logic [2:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_WAIT, W_RESP} w_state_t;

  w_state_t              w_state, w_state_n;
  logic [WC_W-1:0]       w_cnt, w_cnt_n;
  logic [DATA_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic [2:0]            w_strb;
  logic                  aw_hs, w_hs;
  logic                  w_commit;
  logic [1:0]            w_off;
  logic [NBYTES-1:0]     w_mask;
  logic                  w_err;
  logic [DATA_WIDTH-1:0] w_data_sh;
  logic [IDX_W-1:0]      w_idx;

  assign aw_hs = bus.awvalid && bus.awready;
  assign w_hs  = bus.wvalid && bus.wready;

  always_comb begin
    w_state_n = w_state;
    w_cnt_n   = w_cnt;
    w_commit  = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          w_state_n = W_WAIT;
          w_cnt_n   = WC_W'(WR_LAT - 1);
        end else if (aw_hs) begin
          w_state_n = W_HAVE_AW;
        end else if (w_hs) begin
          w_state_n = W_HAVE_W;
        end
      end
      W_HAVE_AW: if (w_hs) begin
        w_state_n = W_WAIT;
        w_cnt_n   = WC_W'(WR_LAT - 1);
      end
      W_HAVE_W: if (aw_hs) begin
        w_state_n = W_WAIT;
        w_cnt_n   = WC_W'(WR_LAT - 1);
      end
      W_WAIT: if (w_cnt == '0) begin
        w_state_n = W_RESP;
        w_commit  = 1'b1;
      end else begin
        w_cnt_n = w_cnt - WC_W'(1);
      end
      W_RESP: if (bus.bready) w_state_n = W_IDLE;
      default: w_state_n = W_IDLE;
    endcase
  end

  // Byte lanes and error check for the captured store
  always_comb begin
    w_off  = w_addr[1:0];
    w_mask = '0;
    w_err  = 1'b0;
    case (w_strb)
      3'b100: begin
        w_mask = 4'b1111;
        w_err  = (w_off != 2'b00);
      end
      3'b010: begin
        w_mask = 4'(4'b0011 << w_off);
        w_err  = w_off[0];
      end
      3'b001:  w_mask = 4'(4'b0001 << w_off);
      default: w_err  = 1'b1;
    endcase
    if (!in_range(w_addr)) w_err = 1'b1;
    w_data_sh = w_data << {w_off, 3'b000};
    w_idx     = word_idx(w_addr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state     <= W_IDLE;
      w_cnt       <= '0;
      w_addr      <= '0;
      w_data      <= '0;
      w_strb      <= '0;
      bus.awready <= 1'b1;
      bus.wready  <= 1'b1;
      bus.bvalid  <= 1'b0;
      bus.bresp   <= RESP_OKAY;
    end else begin
      w_state     <= w_state_n;
      w_cnt       <= w_cnt_n;
      bus.awready <= (w_state_n == W_IDLE) || (w_state_n == W_HAVE_W);
      bus.wready  <= (w_state_n == W_IDLE) || (w_state_n == W_HAVE_AW);
      bus.bvalid  <= (w_state_n == W_RESP);
      if (aw_hs) w_addr <= bus.awaddr;
      if (w_hs) begin
        w_data <= bus.wdata;
        w_strb <= bus.wstrb;
      end
      if (w_commit) bus.bresp <= w_err ? RESP_SLVERR : RESP_OKAY;
    end
  end

  // Array is never reset; a commit coinciding with rst is dropped
  always_ff @(posedge clk) begin
    if (!rst && w_commit && !w_err) begin
      for (int b = 0; b < int'(NBYTES); b++) begin
        if (w_mask[b]) mem[w_idx][8*b +: 8] <= w_data_sh[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dsram_axi_slave.sv
// Bench for dsram_axi_slave: directed scenarios plus randomized stores/loads checked
// against a byte-array model of the SRAM.
module tb_dsram_axi_slave;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int unsigned DEPTH = 4096;
  localparam logic [31:0] RBASE = 32'h8000_0100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  dsram_axi_slave_if bus1 ();
  dsram_axi_slave_if bus3 ();

  dsram_axi_slave #(.RD_LAT(1), .WR_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  dsram_axi_slave #(.RD_LAT(3), .WR_LAT(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  logic [7:0] mb [16][4];

  function automatic logic [31:0] mword(input int k);
    return {mb[k][3], mb[k][2], mb[k][1], mb[k][0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_bus(input virtual dsram_axi_slave_if vif);
    vif.awaddr = '0; vif.awvalid = 1'b0; vif.wdata = '0; vif.wstrb = '0; vif.wvalid = 1'b0;
    vif.bready = 1'b0; vif.araddr = '0; vif.arvalid = 1'b0; vif.rready = 1'b0;
  endtask

  // mode 0: AW and W together, 1: AW then W, 2: W then AW
  task automatic do_write(input virtual dsram_axi_slave_if vif, input logic [31:0] addr,
                          input logic [31:0] data, input logic [2:0] strb, input int mode,
                          input int exp_lat, output logic [1:0] resp);
    int lat;
    @(negedge clk);
    if (mode != 2) begin vif.awvalid = 1'b1; vif.awaddr = addr; end
    if (mode != 1) begin vif.wvalid = 1'b1; vif.wdata = data; vif.wstrb = strb; end
    @(posedge clk); @(negedge clk);
    vif.awvalid = 1'b0; vif.wvalid = 1'b0;
    if (mode == 1) begin
      check("have_aw_ready", {30'd0, vif.awready, vif.wready}, 32'd1);
      vif.wvalid = 1'b1; vif.wdata = data; vif.wstrb = strb;
      @(posedge clk); @(negedge clk);
      vif.wvalid = 1'b0;
    end else if (mode == 2) begin
      check("have_w_ready", {30'd0, vif.awready, vif.wready}, 32'd2);
      vif.awvalid = 1'b1; vif.awaddr = addr;
      @(posedge clk); @(negedge clk);
      vif.awvalid = 1'b0;
    end
    lat = 0;
    while (vif.bvalid !== 1'b1 && lat < 50) begin
      @(posedge clk); @(negedge clk);
      lat++;
    end
    check("wr_latency", 32'(lat), 32'(exp_lat));
    resp = vif.bresp;
    vif.bready = 1'b1;
    @(posedge clk); @(negedge clk);
    vif.bready = 1'b0;
    check("bvalid_drop", {31'd0, vif.bvalid}, 32'd0);
  endtask

  task automatic do_read(input virtual dsram_axi_slave_if vif, input logic [31:0] addr,
                         input int exp_lat, output logic [31:0] data, output logic [1:0] resp);
    int lat;
    @(negedge clk);
    vif.arvalid = 1'b1; vif.araddr = addr;
    @(posedge clk); @(negedge clk);
    vif.arvalid = 1'b0;
    check("arready_busy", {31'd0, vif.arready}, 32'd0);
    lat = 0;
    while (vif.rvalid !== 1'b1 && lat < 50) begin
      @(posedge clk); @(negedge clk);
      lat++;
    end
    check("rd_latency", 32'(lat), 32'(exp_lat));
    data = vif.rdata;
    resp = vif.rresp;
    vif.rready = 1'b1;
    @(posedge clk); @(negedge clk);
    vif.rready = 1'b0;
    check("rvalid_drop", {31'd0, vif.rvalid}, 32'd0);
    check("arready_back", {31'd0, vif.arready}, 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    int          lat;

    idle_bus(bus1);
    idle_bus(bus3);

    // reset values
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_readies", {29'd0, bus1.arready, bus1.awready, bus1.wready}, 32'd7);
    check("rst_valids", {30'd0, bus1.rvalid, bus1.bvalid}, 32'd0);
    check("rst_rdata", bus1.rdata, 32'd0);
    check("rst_resps", {28'd0, bus1.rresp, bus1.bresp}, 32'd0);
    check("rst_dut3", {27'd0, bus3.arready, bus3.awready, bus3.wready, bus3.rvalid, bus3.bvalid},
          32'h1C);
    rst = 1'b0;

    // word store (AW before W) then load
    do_write(bus1, 32'h8000_0010, 32'hDEAD_BEEF, 3'b100, 1, 1, r);
    check("word_bresp", {30'd0, r}, 32'd0);
    do_read(bus1, 32'h8000_0010, 1, d, r);
    check("word_rdata", d, 32'hDEAD_BEEF);
    check("word_rresp", {30'd0, r}, 32'd0);

    // sub-word stores
    do_write(bus1, 32'h8000_0012, 32'h0000_005A, 3'b001, 0, 1, r);
    check("byte_bresp", {30'd0, r}, 32'd0);
    do_read(bus1, 32'h8000_0010, 1, d, r);
    check("byte_merge", d, 32'hDE5A_BEEF);
    do_write(bus1, 32'h8000_0010, 32'h0000_1234, 3'b010, 2, 1, r);
    check("half_bresp", {30'd0, r}, 32'd0);
    do_read(bus1, 32'h8000_0010, 1, d, r);
    check("half_merge", d, 32'hDE5A_1234);
    do_read(bus1, 32'h8000_0013, 1, d, r);
    check("shifted_load", d, 32'h0000_00DE);

    // error responses
    do_write(bus1, 32'h8000_0012, 32'hFFFF_FFFF, 3'b100, 0, 1, r);
    check("misalign_bresp", {30'd0, r}, 32'd2);
    do_read(bus1, 32'h8000_0010, 1, d, r);
    check("misalign_nochange", d, 32'hDE5A_1234);
    do_read(bus1, 32'h7FFF_FFFC, 1, d, r);
    check("oor_low_rresp", {30'd0, r}, 32'd2);
    check("oor_low_rdata", d, 32'd0);
    do_read(bus1, BASE + 4 * DEPTH, 1, d, r);
    check("oor_high_rresp", {30'd0, r}, 32'd2);
    do_write(bus1, 32'h8000_0010, 32'hFFFF_FFFF, 3'b011, 0, 1, r);
    check("badstrb_bresp", {30'd0, r}, 32'd2);
    do_read(bus1, 32'h8000_0010, 1, d, r);
    check("badstrb_nochange", d, 32'hDE5A_1234);

    // backpressure on both channels
    @(negedge clk);
    bus1.arvalid = 1'b1; bus1.araddr = 32'h8000_0010;
    bus1.awvalid = 1'b1; bus1.awaddr = 32'h8000_0020;
    bus1.wvalid = 1'b1; bus1.wdata = 32'hCAFE_F00D; bus1.wstrb = 3'b100;
    @(posedge clk); @(negedge clk);
    bus1.arvalid = 1'b0; bus1.awvalid = 1'b0; bus1.wvalid = 1'b0;
    lat = 0;
    while (!(bus1.rvalid === 1'b1 && bus1.bvalid === 1'b1) && lat < 50) begin
      @(posedge clk); @(negedge clk);
      lat++;
    end
    check("bp_both_lat", 32'(lat), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      check("bp_flags", {28'd0, bus1.rvalid, bus1.bvalid, bus1.arready, bus1.awready}, 32'hC);
      check("bp_rdata", bus1.rdata, 32'hDE5A_1234);
      check("bp_resps", {28'd0, bus1.rresp, bus1.bresp}, 32'd0);
    end
    bus1.rready = 1'b1; bus1.bready = 1'b1;
    @(posedge clk); @(negedge clk);
    bus1.rready = 1'b0; bus1.bready = 1'b0;
    check("bp_release", {28'd0, bus1.rvalid, bus1.bvalid, bus1.arready, bus1.awready}, 32'h3);
    do_read(bus1, 32'h8000_0020, 1, d, r);
    check("bp_write_data", d, 32'hCAFE_F00D);

    // concurrent read/write collision with latency 3
    do_write(bus3, 32'h8000_0040, 32'h1111_1111, 3'b100, 0, 3, r);
    check("conc_init_bresp", {30'd0, r}, 32'd0);
    @(negedge clk);
    bus3.arvalid = 1'b1; bus3.araddr = 32'h8000_0040;
    bus3.awvalid = 1'b1; bus3.awaddr = 32'h8000_0040;
    bus3.wvalid = 1'b1; bus3.wdata = 32'h2222_2222; bus3.wstrb = 3'b100;
    @(posedge clk); @(negedge clk);
    bus3.arvalid = 1'b0; bus3.awvalid = 1'b0; bus3.wvalid = 1'b0;
    lat = 0;
    while (!(bus3.rvalid === 1'b1 && bus3.bvalid === 1'b1) && lat < 50) begin
      @(posedge clk); @(negedge clk);
      lat++;
    end
    check("conc_lat", 32'(lat), 32'd3);
    check("conc_old_data", bus3.rdata, 32'h1111_1111);
    check("conc_resps", {28'd0, bus3.rresp, bus3.bresp}, 32'd0);
    bus3.rready = 1'b1; bus3.bready = 1'b1;
    @(posedge clk); @(negedge clk);
    bus3.rready = 1'b0; bus3.bready = 1'b0;
    do_read(bus3, 32'h8000_0040, 3, d, r);
    check("conc_new_data", d, 32'h2222_2222);

    // reset while a read is waiting
    @(negedge clk);
    bus3.arvalid = 1'b1; bus3.araddr = 32'h8000_0040;
    @(posedge clk); @(negedge clk);
    bus3.arvalid = 1'b0;
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    check("rst_rwait_arready", {31'd0, bus3.arready}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      check("rst_rwait_no_rvalid", {31'd0, bus3.rvalid}, 32'd0);
    end

    // reset before commit abandons the store
    do_write(bus3, 32'h8000_0044, 32'hAAAA_0000, 3'b100, 0, 3, r);
    @(negedge clk);
    bus3.awvalid = 1'b1; bus3.awaddr = 32'h8000_0044;
    bus3.wvalid = 1'b1; bus3.wdata = 32'h5555_5555; bus3.wstrb = 3'b100;
    @(posedge clk); @(negedge clk);
    bus3.awvalid = 1'b0; bus3.wvalid = 1'b0;
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    check("rst_wwait_readies", {30'd0, bus3.awready, bus3.wready}, 32'd3);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); @(negedge clk);
      check("rst_wwait_no_bvalid", {31'd0, bus3.bvalid}, 32'd0);
    end
    do_read(bus3, 32'h8000_0044, 3, d, r);
    check("rst_abandon_data", d, 32'hAAAA_0000);

    // randomized stores/loads against the byte model
    for (int k = 0; k < 16; k++) begin
      logic [31:0] v;
      v = $urandom;
      do_write(bus1, RBASE + 32'(4 * k), v, 3'b100, $urandom_range(0, 2), 1, r);
      check("rnd_init_bresp", {30'd0, r}, 32'd0);
      for (int b = 0; b < 4; b++) mb[k][b] = v[8*b +: 8];
    end
    for (int it = 0; it < 80; it++) begin
      int          k, off, sel, size, rk, roff;
      logic        oor, ok;
      logic [2:0]  st;
      logic [31:0] a, dat, exp_rd;
      logic [2:0]  bad [4];
      bad[0] = 3'b000; bad[1] = 3'b011; bad[2] = 3'b111; bad[3] = 3'b110;
      k   = $urandom_range(0, 15);
      off = $urandom_range(0, 3);
      sel = $urandom_range(0, 9);
      st  = (sel < 3) ? 3'b100 : (sel < 6) ? 3'b010 : (sel < 8) ? 3'b001
                                            : bad[$urandom_range(0, 3)];
      oor = ($urandom_range(0, 9) == 0);
      if (oor) a = ($urandom_range(0, 1) == 1) ? (BASE - 32'd4 + 32'(off))
                                                : (BASE + 32'(4 * DEPTH) + 32'(off));
      else     a = RBASE + 32'(4 * k) + 32'(off);
      dat  = $urandom;
      size = (st == 3'b100) ? 4 : (st == 3'b010) ? 2 : (st == 3'b001) ? 1 : 0;
      ok   = !oor && (size != 0) && ((off % (size == 0 ? 1 : size)) == 0);
      do_write(bus1, a, dat, st, $urandom_range(0, 2), 1, r);
      check("rnd_bresp", {30'd0, r}, ok ? 32'd0 : 32'd2);
      if (ok) for (int i = 0; i < size; i++) mb[k][off + i] = dat[8*i +: 8];
      rk   = ($urandom_range(0, 1) == 1) ? k : $urandom_range(0, 15);
      roff = $urandom_range(0, 3);
      if ($urandom_range(0, 11) == 0) begin
        do_read(bus1, BASE - 32'd16 + 32'(roff), 1, d, r);
        check("rnd_oor_rresp", {30'd0, r}, 32'd2);
        check("rnd_oor_rdata", d, 32'd0);
      end else begin
        do_read(bus1, RBASE + 32'(4 * rk) + 32'(roff), 1, d, r);
        exp_rd = mword(rk) >> (8 * roff);
        check("rnd_rresp", {30'd0, r}, 32'd0);
        check("rnd_rdata", d, exp_rd);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
